order_book_engine: RTL

//  Parametrised successor to the single-pair matcher: keeps a sorted resting book of up to DEPTH

---
 rtl/order_book_engine.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/order_book_engine.sv
// order_book_engine
//   Limit-order matcher with a sorted resting book of up to DEPTH bids and
//   DEPTH asks. Each accepted order either trades against the best opposite
//   entry or is inserted into its own side. The engine counts trades and
//   halts once MAX_TRADES trades have occurred.
//
//   Optional feature macro: OBOOK_VALUE_SUM_EN. When defined, value_sum
//   accumulates trade prices and saturates at all-ones. When undefined,
//   value_sum is tied to 0.
//
//   Handshake: an order is taken at a rising clk edge when in_valid &
//   in_ready. in_ready is (state==ACTIVE) & !clear and has no dependence on
//   in_valid. Results appear on the cycle after acceptance.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   enable            level, run the engine (IDLE <-> ACTIVE)
//   clear             pulse, empty the book, zero count/sum, go IDLE
//   in_valid/in_ready order handshake; in_side 0=buy 1=sell; in_price limit
//   trade_valid       one-cycle pulse per trade
//   trade_price/side  last trade (held)
//   drop_pulse        one-cycle pulse, order discarded (full, not better)
//   best_bid/best_ask top of book (0 / all-ones when empty)
//   bid_cnt/ask_cnt   resting entries per side
//   spread            best_ask-best_bid when both sides non-empty, else 0
//   trade_count       trades since reset/clear
//   state, halted     FSM state (0 IDLE, 1 ACTIVE, 2 HALTED), state==HALTED
//   value_sum         accumulated trade prices (feature-dependent)
module order_book_engine #(
  parameter int PW         = 8,
  parameter int DEPTH      = 4,
  parameter int MAX_TRADES = 99,
  parameter int CW         = 8,
  localparam int NW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_side,
  input  logic [PW-1:0]    in_price,
  output logic             trade_valid,
  output logic [PW-1:0]    trade_price,
  output logic             trade_side,
  output logic             drop_pulse,
  output logic [PW-1:0]    best_bid,
  output logic [PW-1:0]    best_ask,
  output logic [NW-1:0]    bid_cnt,
  output logic [NW-1:0]    ask_cnt,
  output logic [PW-1:0]    spread,
  output logic [CW-1:0]    trade_count,
  output logic [1:0]       state,
  output logic             halted,
  output logic [PW+CW-1:0] value_sum
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state_q, state_n;

  // Unused slots hold the empty-side value (0 for bids, all-ones for asks)
  // so that slot 0 is directly the best price.
  logic [PW-1:0] bid_q [DEPTH];
  logic [PW-1:0] ask_q [DEPTH];
  logic [PW-1:0] bid_n [DEPTH];
  logic [PW-1:0] ask_n [DEPTH];
  logic [NW-1:0] bid_cnt_q, ask_cnt_q, bid_cnt_n, ask_cnt_n;
  logic [NW-1:0] pos;
  logic          accept, do_trade, do_drop;
  logic [PW-1:0] t_price;
  logic [CW-1:0] count_q;
  logic          trade_valid_q, drop_q, trade_side_q;
  logic [PW-1:0] trade_price_q;

  assign accept = in_valid & in_ready;

  // Book update. pos is the insertion slot: the number of resting entries
  // that are at least as good as the new order, so ties queue behind.
  always_comb begin
    bid_n     = bid_q;
    ask_n     = ask_q;
    bid_cnt_n = bid_cnt_q;
    ask_cnt_n = ask_cnt_q;
    do_trade  = 1'b0;
    do_drop   = 1'b0;
    t_price   = '0;
    pos       = '0;
    if (accept) begin
      if (!in_side) begin
        if (ask_cnt_q != '0 && in_price >= ask_q[0]) begin
          do_trade = 1'b1;
          t_price  = ask_q[0];
          for (int i = 0; i < DEPTH - 1; i++) ask_n[i] = ask_q[i+1];
          ask_n[DEPTH-1] = '1;
          ask_cnt_n = ask_cnt_q - NW'(1);
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (NW'(i) < bid_cnt_q && bid_q[i] >= in_price) pos = pos + NW'(1);
          if (pos == NW'(DEPTH)) begin
            do_drop = 1'b1;
          end else begin
            for (int i = 1; i < DEPTH; i++)
              if (NW'(i) > pos) bid_n[i] = bid_q[i-1];
            for (int i = 0; i < DEPTH; i++)
              if (NW'(i) == pos) bid_n[i] = in_price;
            if (bid_cnt_q != NW'(DEPTH)) bid_cnt_n = bid_cnt_q + NW'(1);
          end
        end
      end else begin
        if (bid_cnt_q != '0 && in_price <= bid_q[0]) begin
          do_trade = 1'b1;
          t_price  = bid_q[0];
          for (int i = 0; i < DEPTH - 1; i++) bid_n[i] = bid_q[i+1];
          bid_n[DEPTH-1] = '0;
          bid_cnt_n = bid_cnt_q - NW'(1);
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (NW'(i) < ask_cnt_q && ask_q[i] <= in_price) pos = pos + NW'(1);
          if (pos == NW'(DEPTH)) begin
            do_drop = 1'b1;
          end else begin
            for (int i = 1; i < DEPTH; i++)
              if (NW'(i) > pos) ask_n[i] = ask_q[i-1];
            for (int i = 0; i < DEPTH; i++)
              if (NW'(i) == pos) ask_n[i] = in_price;
            if (ask_cnt_q != NW'(DEPTH)) ask_cnt_n = ask_cnt_q + NW'(1);
          end
        end
      end
    end
  end

  // Halting is decided on the trade that brings the count to MAX_TRADES,
  // so no further order can be accepted once the limit is reached.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_n = ST_ACTIVE;
      ST_ACTIVE: begin
        if (do_trade && (count_q + CW'(1)) == CW'(MAX_TRADES)) state_n = ST_HALTED;
        else if (!enable) state_n = ST_IDLE;
      end
      ST_HALTED: state_n = ST_HALTED;
      default:   state_n = ST_IDLE;
    endcase
    if (clear) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        bid_q[i] <= '0;
        ask_q[i] <= '1;
      end
      bid_cnt_q     <= '0;
      ask_cnt_q     <= '0;
      count_q       <= '0;
      trade_valid_q <= 1'b0;
      drop_q        <= 1'b0;
      if (reset) begin
        trade_price_q <= '0;
        trade_side_q  <= 1'b0;
      end
    end else begin
      bid_q         <= bid_n;
      ask_q         <= ask_n;
      bid_cnt_q     <= bid_cnt_n;
      ask_cnt_q     <= ask_cnt_n;
      trade_valid_q <= do_trade;
      drop_q        <= do_drop;
      if (do_trade) begin
        trade_price_q <= t_price;
        trade_side_q  <= in_side;
        count_q       <= count_q + CW'(1);
      end
    end
  end

`ifdef OBOOK_VALUE_SUM_EN
  logic [PW+CW-1:0] sum_q;
  logic [PW+CW:0]   sum_ext;
  assign sum_ext = {1'b0, sum_q} + {{(CW+1){1'b0}}, t_price};
  always_ff @(posedge clk) begin
    if (reset || clear)  sum_q <= '0;
    else if (do_trade)   sum_q <= sum_ext[PW+CW] ? '1 : sum_ext[PW+CW-1:0];
  end
  assign value_sum = sum_q;
`else
  assign value_sum = '0;
`endif

  assign in_ready    = (state_q == ST_ACTIVE) & !clear;
  assign trade_valid = trade_valid_q;
  assign trade_price = trade_price_q;
  assign trade_side  = trade_side_q;
  assign drop_pulse  = drop_q;
  assign best_bid    = bid_q[0];
  assign best_ask    = ask_q[0];
  assign bid_cnt     = bid_cnt_q;
  assign ask_cnt     = ask_cnt_q;
  assign spread      = (bid_cnt_q != '0 && ask_cnt_q != '0) ? (ask_q[0] - bid_q[0]) : '0;
  assign trade_count = count_q;
  assign state       = state_q;
  assign halted      = (state_q == ST_HALTED);

endmodule
